// File: rtl/present_pkg.sv
// Shared PRESENT constants and the key-schedule FSM state type.
// No ports; imported by the key-schedule inverter and its helpers.
package present_pkg;

   localparam int unsigned NUM_ROUNDS  = 31;
   localparam int unsigned KEY80_SIZE  = 80;
   localparam int unsigned KEY128_SIZE = 128;
   localparam int unsigned RK_SIZE     = 64;

   typedef enum logic [1:0] {
      StIdle,
      StFwd,
      StEmit,
      StDone
   } ksa_state_e;

endpackage

// File: rtl/SBox.sv
// Forward PRESENT 4-bit S-box (purely combinational).
// Ports: in_i - nibble in, out_o - substituted nibble out.
module SBox (
   input  logic [3:0] in_i,
   output logic [3:0] out_o
);

   always_comb begin
      unique case (in_i)
         4'h0: out_o = 4'hC;
         4'h1: out_o = 4'h5;
         4'h2: out_o = 4'h6;
         4'h3: out_o = 4'hB;
         4'h4: out_o = 4'h9;
         4'h5: out_o = 4'h0;
         4'h6: out_o = 4'hA;
         4'h7: out_o = 4'hD;
         4'h8: out_o = 4'h3;
         4'h9: out_o = 4'hE;
         4'hA: out_o = 4'hF;
         4'hB: out_o = 4'h8;
         4'hC: out_o = 4'h4;
         4'hD: out_o = 4'h7;
         4'hE: out_o = 4'h1;
         4'hF: out_o = 4'h2;
      endcase
   end

endmodule

// File: rtl/present_inv_sbox.sv
// Inverse PRESENT 4-bit S-box (purely combinational).
// Ports: in_i - nibble in, out_o - inverse-substituted nibble out.
module present_inv_sbox (
   input  logic [3:0] in_i,
   output logic [3:0] out_o
);

   always_comb begin
      unique case (in_i)
         4'h0: out_o = 4'h5;
         4'h1: out_o = 4'hE;
         4'h2: out_o = 4'hF;
         4'h3: out_o = 4'h8;
         4'h4: out_o = 4'hC;
         4'h5: out_o = 4'h1;
         4'h6: out_o = 4'h2;
         4'h7: out_o = 4'hD;
         4'h8: out_o = 4'hB;
         4'h9: out_o = 4'h4;
         4'hA: out_o = 4'h6;
         4'hB: out_o = 4'h3;
         4'hC: out_o = 4'h0;
         4'hD: out_o = 4'h7;
         4'hE: out_o = 4'h9;
         4'hF: out_o = 4'hA;
      endcase
   end

endmodule

// File: rtl/ksa_inv.sv
// PRESENT decryption key schedule: runs the forward schedule to K32, then emits
// round keys K32..K1 over a valid/ready port, undoing one round per handshake.
// Build option: define KSA_KEY128_EN for a 128-bit register, the key_len_128
// port and a per-run choice of 80- or 128-bit schedule; default is 80-bit only.
// Ports:
//   clk, rst_n (sync, active-low)  start, master_key[127:0], key_len_128 (opt)
//   rk[63:0], rk_idx[5:0], rk_valid, rk_ready (in), busy, done (1-cycle pulse)
module ksa_inv
   import present_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] master_key,
`ifdef KSA_KEY128_EN
   input  logic         key_len_128,
`endif
   output logic [63:0]  rk,
   output logic [5:0]   rk_idx,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

`ifdef KSA_KEY128_EN
   localparam int unsigned KeyW = KEY128_SIZE;
`else
   localparam int unsigned KeyW = KEY80_SIZE;
`endif

   ksa_state_e      state_q, state_d;
   logic [KeyW-1:0] key_q, key_d, key_load, key_fwd, key_inv;
   logic [4:0]      ctr_q, ctr_d;
   logic [5:0]      rk_idx_q, rk_idx_d;
   logic            rk_valid_q, rk_valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [4:0]      inv_ctr;

   // Undoing the step that produced K[idx] needs round constant idx-1.
   assign inv_ctr = 5'(rk_idx_q - 6'd1);

   // 80-bit round arithmetic always acts on the low 80 register bits.
   logic [79:0] k80, rot80, fwd80, pre80, inv80;
   logic [3:0]  sb_a_in, sb_a_out, isb_a_in, isb_a_out;

   assign k80   = key_q[79:0];
   assign rot80 = {k80[18:0], k80[79:19]};

   SBox u_sbox_a (
      .in_i  (sb_a_in),
      .out_o (sb_a_out)
   );

   present_inv_sbox u_inv_sbox_a (
      .in_i  (isb_a_in),
      .out_o (isb_a_out)
   );

   always_comb begin
      fwd80          = rot80;
      fwd80[79:76]   = sb_a_out;
      fwd80[19:15]   = fwd80[19:15] ^ ctr_q;
      pre80          = k80;
      pre80[19:15]   = pre80[19:15] ^ inv_ctr;
      pre80[79:76]   = isb_a_out;
      inv80          = {pre80[60:0], pre80[79:61]};
   end

`ifdef KSA_KEY128_EN
   logic         len128_q, len128_d;
   logic [127:0] rot128, fwd128, pre128, inv128;
   logic [3:0]   sb_b_out, isb_b_out;

   assign rot128   = {key_q[66:0], key_q[127:67]};
   // Nibble "a" serves [79:76] in 80-bit runs and [127:124] in 128-bit runs.
   assign sb_a_in  = len128_q ? rot128[127:124] : rot80[79:76];
   assign isb_a_in = len128_q ? key_q[127:124] : k80[79:76];

   SBox u_sbox_b (
      .in_i  (rot128[123:120]),
      .out_o (sb_b_out)
   );

   present_inv_sbox u_inv_sbox_b (
      .in_i  (key_q[123:120]),
      .out_o (isb_b_out)
   );

   always_comb begin
      fwd128          = rot128;
      fwd128[127:124] = sb_a_out;
      fwd128[123:120] = sb_b_out;
      fwd128[66:62]   = fwd128[66:62] ^ ctr_q;
      pre128          = key_q;
      pre128[66:62]   = pre128[66:62] ^ inv_ctr;
      pre128[127:124] = isb_a_out;
      pre128[123:120] = isb_b_out;
      inv128          = {pre128[60:0], pre128[127:61]};
   end

   // In 80-bit runs the upper 48 register bits stay zero.
   assign key_load = key_len_128 ? master_key : {48'd0, master_key[79:0]};
   assign key_fwd  = len128_q ? fwd128 : {key_q[127:80], fwd80};
   assign key_inv  = len128_q ? inv128 : {key_q[127:80], inv80};
   assign rk       = len128_q ? key_q[127:64] : key_q[79:16];
`else
   logic unused_key_hi;
   assign unused_key_hi = ^master_key[127:80];
   assign sb_a_in       = rot80[79:76];
   assign isb_a_in      = k80[79:76];
   assign key_load      = master_key[79:0];
   assign key_fwd       = fwd80;
   assign key_inv       = inv80;
   assign rk            = key_q[79:16];
`endif

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      ctr_d      = ctr_q;
      rk_idx_d   = rk_idx_q;
      rk_valid_d = rk_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
`ifdef KSA_KEY128_EN
      len128_d   = len128_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFwd;
               key_d   = key_load;
               ctr_d   = 5'd1;
               busy_d  = 1'b1;
`ifdef KSA_KEY128_EN
               len128_d = key_len_128;
`endif
            end
         end
         StFwd: begin
            key_d = key_fwd;
            ctr_d = ctr_q + 5'd1;
            if (ctr_q == 5'(NUM_ROUNDS)) begin
               state_d    = StEmit;
               rk_valid_d = 1'b1;
               rk_idx_d   = 6'(NUM_ROUNDS + 1);
            end
         end
         StEmit: begin
            if (rk_ready) begin
               if (rk_idx_q == 6'd1) begin
                  // K1 is the loaded key; nothing left to undo.
                  state_d    = StDone;
                  rk_valid_d = 1'b0;
                  rk_idx_d   = 6'd0;
                  done_d     = 1'b1;
               end else begin
                  rk_idx_d = rk_idx_q - 6'd1;
                  key_d    = key_inv;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         key_q      <= '0;
         ctr_q      <= '0;
         rk_idx_q   <= '0;
         rk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef KSA_KEY128_EN
         len128_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         ctr_q      <= ctr_d;
         rk_idx_q   <= rk_idx_d;
         rk_valid_q <= rk_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef KSA_KEY128_EN
         len128_q   <= len128_d;
`endif
      end
   end

   assign rk_idx   = rk_idx_q;
   assign rk_valid = rk_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_ksa_inv.sv
// Randomized self-checking bench for ksa_inv against a forward-schedule model.
module tb_ksa_inv;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] master_key;
`ifdef KSA_KEY128_EN
   logic         key_len_128;
`endif
   logic [63:0]  rk;
   logic [5:0]   rk_idx;
   logic         rk_valid;
   logic         rk_ready;
   logic         busy;
   logic         done;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0]  sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
   logic [63:0] golden [33];
   logic [63:0] got_rk [33];

   ksa_inv u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .master_key (master_key),
`ifdef KSA_KEY128_EN
      .key_len_128(key_len_128),
`endif
      .rk         (rk),
      .rk_idx     (rk_idx),
      .rk_valid   (rk_valid),
      .rk_ready   (rk_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Forward PRESENT schedule: golden[r] is round key K_r.
   function automatic void build_golden(input logic [127:0] mk, input bit l128);
      logic [79:0]  k80;
      logic [127:0] k128;
      k80  = mk[79:0];
      k128 = mk;
      for (int r = 1; r <= 32; r++) begin
         logic [4:0] rc;
         rc = r[4:0];
         if (l128) begin
            golden[r] = k128[127:64];
            k128 = (k128 << 61) | (k128 >> 67);
            k128[127:124] = sbox_t[k128[127:124]];
            k128[123:120] = sbox_t[k128[123:120]];
            k128[66:62]   = k128[66:62] ^ rc;
         end else begin
            golden[r] = k80[79:16];
            k80 = (k80 << 61) | (k80 >> 19);
            k80[79:76] = sbox_t[k80[79:76]];
            k80[19:15] = k80[19:15] ^ rc;
         end
      end
   endfunction

   task automatic run_sched(input logic [127:0] mk, input bit l128, input int stall_pct,
                            input bit inject, input int abort_at);
      int cyc;
      int ncyc;
      int exp_idx;
      bit rdy;
      bit bad;
      build_golden(mk, l128);
      @(posedge clk); #1;
      start      = 1'b1;
      master_key = mk;
`ifdef KSA_KEY128_EN
      key_len_128 = l128;
`endif
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!rk_valid && cyc < 64) begin
         start = inject && (cyc == 5);
         if (start) master_key = ~mk;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check_eq("latency", 64'(cyc), 64'd32);
      if (!rk_valid) return;

      exp_idx = 32;
      ncyc    = 0;
      while (exp_idx >= 1 && ncyc < 400) begin
         if (abort_at != 0 && exp_idx == abort_at) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n    = 1'b1;
            rk_ready = 1'b0;
            check_eq("abort_valid", 64'(rk_valid), 64'd0);
            check_eq("abort_busy", 64'(busy), 64'd0);
            check_eq("abort_done", 64'(done), 64'd0);
            check_eq("abort_rk", rk, 64'd0);
            check_eq("abort_idx", 64'(rk_idx), 64'd0);
            bad = 1'b0;
            repeat (40) begin
               @(posedge clk); #1;
               if (done || rk_valid || busy) bad = 1'b1;
            end
            check_eq("abort_quiet", 64'(bad), 64'd0);
            return;
         end
         check_eq("valid", 64'(rk_valid), 64'd1);
         check_eq("rk_idx", 64'(rk_idx), 64'(exp_idx));
         check_eq($sformatf("rk[%0d]", exp_idx), rk, golden[exp_idx]);
         got_rk[exp_idx] = rk;
         rdy      = ($urandom_range(99, 0) >= stall_pct);
         rk_ready = rdy;
         start    = inject && (ncyc == 10);
         if (start) master_key = ~mk;
         @(posedge clk); #1;
         ncyc++;
         if (rdy) exp_idx--;
      end
      rk_ready = 1'b0;
      start    = 1'b0;
      check_eq("all_handshakes", 64'(exp_idx), 64'd0);
      if (stall_pct == 0) check_eq("emit_cycles", 64'(ncyc), 64'd32);
      check_eq("done_pulse", 64'(done), 64'd1);
      check_eq("valid_drop", 64'(rk_valid), 64'd0);
      check_eq("busy_in_done", 64'(busy), 64'd1);
      @(posedge clk); #1;
      check_eq("done_clear", 64'(done), 64'd0);
      check_eq("busy_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      rk_ready   = 1'b0;
      master_key = '0;
`ifdef KSA_KEY128_EN
      key_len_128 = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_rk", rk, 64'd0);
      check_eq("rst_idx", 64'(rk_idx), 64'd0);
      check_eq("rst_valid", 64'(rk_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;

      // All-zero 80-bit key, no backpressure.
      run_sched(128'd0, 1'b0, 0, 1'b0, 0);
      check_eq("zero_k2", got_rk[2], 64'hC000000000000000);
      check_eq("zero_k1", got_rk[1], 64'h0000000000000000);

      // All-ones 80-bit key (upper bits set too; they must be ignored).
      run_sched({128{1'b1}}, 1'b0, 0, 1'b0, 0);
      check_eq("ones_k1", got_rk[1], 64'hFFFFFFFFFFFFFFFF);

      // Random keys with 50% backpressure.
      for (int t = 0; t < 3; t++)
         run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b0, 50, 1'b0, 0);

      // Stray start pulses during FWD and EMIT.
      run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b0, 30, 1'b1, 0);

      // Reset mid-EMIT at rk_idx=17, then a fresh run.
      run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 1'b0, 17);
      run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 1'b0, 0);

`ifdef KSA_KEY128_EN
      run_sched(128'd0, 1'b1, 0, 1'b0, 0);
      check_eq("k128_zero_k1", got_rk[1], 64'h0000000000000000);
      run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b1, 50, 1'b0, 0);
      run_sched({$urandom, $urandom, $urandom, $urandom}, 1'b0, 50, 1'b0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
